// File: rtl/inst_sram_axi_rd_bridge.sv
// Instruction-side SRAM-like slave to single-beat AXI4 read bridge.
// Returns read data in order with up to MAX_OUTSTANDING reads in flight.
module inst_sram_axi_rd_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [3:0]  ARID            = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,
  // SRAM-like slave port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // AXI read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // status
  output logic [1:0]  rd_outstanding,
  output logic        rresp_err,
  output logic        wr_req_err
);

  localparam int unsigned CNT_W  = 2;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_BUSY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [1:0]        arsize_q, arsize_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rready_q;
  logic              data_ok_q;
  logic              rresp_err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              wr_req_err_q;

  logic accept_c;
  logic r_fire_c;
  logic dec_c;
  logic unused_c;

  // Write-side and single-beat/ID-only fields carry no information here
  assign unused_c = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast};

  assign accept_c = inst_sram_req & ~inst_sram_wr & (state_q == AR_IDLE)
                  & (count_q < CNT_W'(MAX_OUTSTANDING));
  assign r_fire_c = rvalid & rready_q;
  // A stray beat with nothing outstanding must not underflow the counter
  assign dec_c    = data_ok_q & (count_q != CNT_W'(0));

  // AR channel next-state
  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    case (state_q)
      AR_IDLE: begin
        if (accept_c) begin
          state_d   = AR_BUSY;
          arvalid_d = 1'b1;
          araddr_d  = inst_sram_addr;
          arsize_d  = inst_sram_size;
        end
      end
      AR_BUSY: begin
        if (arvalid_q & arready) begin
          state_d   = AR_IDLE;
          arvalid_d = 1'b0;
        end
      end
      default: begin
        state_d   = AR_IDLE;
        arvalid_d = 1'b0;
      end
    endcase
  end

  // Outstanding count; simultaneous inc/dec cancels
  always_comb begin
    count_d = count_q;
    case ({accept_c, dec_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= AR_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      count_q   <= count_d;
    end
  end

  // R capture: one-cycle data_ok pulse, rdata held between returns
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rready_q     <= 1'b0;
      data_ok_q    <= 1'b0;
      rresp_err_q  <= 1'b0;
      rdata_q      <= '0;
      wr_req_err_q <= 1'b0;
    end else begin
      rready_q     <= 1'b1;
      data_ok_q    <= r_fire_c;
      rresp_err_q  <= r_fire_c & (rresp != 2'b00);
      if (r_fire_c) begin
        rdata_q <= rdata;
      end
      wr_req_err_q <= wr_req_err_q | (inst_sram_req & inst_sram_wr);
    end
  end

  assign inst_sram_addr_ok = accept_c;
  assign inst_sram_data_ok = data_ok_q;
  assign inst_sram_rdata   = rdata_q;

  assign arid    = ARID;
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, arsize_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign rd_outstanding = count_q;
  assign rresp_err      = rresp_err_q;
  assign wr_req_err     = wr_req_err_q;

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// Directed self-checking bench for inst_sram_axi_rd_bridge.
module tb_inst_sram_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [1:0]  rd_outstanding;
  logic        rresp_err;
  logic        wr_req_err;

  int tests_run = 0;
  int tests_failed = 0;

  inst_sram_axi_rd_bridge #(.MAX_OUTSTANDING(2), .ARID(4'd0)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .arid              (arid),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arlock            (arlock),
    .arcache           (arcache),
    .arprot            (arprot),
    .arvalid           (arvalid),
    .arready           (arready),
    .rid               (rid),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready),
    .rd_outstanding    (rd_outstanding),
    .rresp_err         (rresp_err),
    .wr_req_err        (wr_req_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read with arready ready at once and R one cycle after the AR handshake
  task automatic single_read(input string tag, input logic [31:0] a,
                             input logic [1:0] sz, input logic [31:0] d);
    inst_sram_req  = 1'b1;
    inst_sram_addr = a;
    inst_sram_size = sz;
    arready        = 1'b1;
    #1;
    chk({tag, "_addr_ok"}, 32'(inst_sram_addr_ok), 32'd1);
    tick();
    inst_sram_req = 1'b0;
    #1;
    chk({tag, "_arvalid"}, 32'(arvalid), 32'd1);
    chk({tag, "_araddr"}, araddr, a);
    chk({tag, "_arsize"}, 32'(arsize), 32'({1'b0, sz}));
    chk({tag, "_cnt1"}, 32'(rd_outstanding), 32'd1);
    tick();
    #1;
    chk({tag, "_ar_done"}, 32'(arvalid), 32'd0);
    rvalid = 1'b1;
    rdata  = d;
    rresp  = 2'b00;
    tick();
    rvalid = 1'b0;
    #1;
    chk({tag, "_data_ok"}, 32'(inst_sram_data_ok), 32'd1);
    chk({tag, "_rdata"}, inst_sram_rdata, d);
    chk({tag, "_rresp_err"}, 32'(rresp_err), 32'd0);
    tick();
    #1;
    chk({tag, "_data_ok_drop"}, 32'(inst_sram_data_ok), 32'd0);
    chk({tag, "_rdata_hold"}, inst_sram_rdata, d);
    chk({tag, "_cnt0"}, 32'(rd_outstanding), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn          = 1'b0;
    inst_sram_req   = 1'b0;
    inst_sram_wr    = 1'b0;
    inst_sram_size  = 2'd0;
    inst_sram_wstrb = 4'd0;
    inst_sram_addr  = 32'd0;
    inst_sram_wdata = 32'd0;
    arready         = 1'b0;
    rid             = 4'd0;
    rdata           = 32'd0;
    rresp           = 2'b00;
    rlast           = 1'b1;
    rvalid          = 1'b0;

    // reset state (one clock edge already seen with reset asserted)
    #12;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    chk("rst_data_ok", 32'(inst_sram_data_ok), 32'd0);
    chk("rst_rdata", inst_sram_rdata, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arsize", 32'(arsize), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_cnt", 32'(rd_outstanding), 32'd0);
    chk("rst_wr_err", 32'(wr_req_err), 32'd0);
    chk("rst_arlen", 32'(arlen), 32'd0);
    chk("rst_arburst", 32'(arburst), 32'd1);
    chk("rst_arid", 32'(arid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    #1;
    chk("rready_up", 32'(rready), 32'd1);

    // single read
    single_read("t1", 32'h1c000000, 2'd2, 32'h02800000);

    // back-to-back reads up to the outstanding limit, R delayed
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c000000;
    inst_sram_size = 2'd2;
    arready        = 1'b1;
    #1;
    chk("t2_acc0", 32'(inst_sram_addr_ok), 32'd1);
    tick();
    inst_sram_addr = 32'h1c000004;
    #1;
    chk("t2_gap", 32'(inst_sram_addr_ok), 32'd0);
    chk("t2_araddr0", araddr, 32'h1c000000);
    tick();
    #1;
    chk("t2_acc1", 32'(inst_sram_addr_ok), 32'd1);
    tick();
    inst_sram_addr = 32'h1c000008;
    #1;
    chk("t2_gap1", 32'(inst_sram_addr_ok), 32'd0);
    chk("t2_araddr1", araddr, 32'h1c000004);
    chk("t2_cnt2", 32'(rd_outstanding), 32'd2);
    tick();
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("t2_full_hold", 32'(inst_sram_addr_ok), 32'd0);
      tick();
    end
    rvalid = 1'b1;
    rdata  = 32'h1c000000;
    #1;
    chk("t2_full_hold_r", 32'(inst_sram_addr_ok), 32'd0);
    tick();
    rdata = 32'h1c000004;
    #1;
    chk("t2_dok0", 32'(inst_sram_data_ok), 32'd1);
    chk("t2_rdata0", inst_sram_rdata, 32'h1c000000);
    chk("t2_full_dok", 32'(inst_sram_addr_ok), 32'd0);
    tick();
    rvalid = 1'b0;
    #1;
    chk("t2_dok1", 32'(inst_sram_data_ok), 32'd1);
    chk("t2_rdata1", inst_sram_rdata, 32'h1c000004);
    chk("t2_acc2", 32'(inst_sram_addr_ok), 32'd1);
    tick();
    inst_sram_req = 1'b0;
    #1;
    chk("t2_dok_drop", 32'(inst_sram_data_ok), 32'd0);
    chk("t2_cnt_same", 32'(rd_outstanding), 32'd1);
    chk("t2_arvalid2", 32'(arvalid), 32'd1);
    chk("t2_araddr2", araddr, 32'h1c000008);
    tick();
    rvalid = 1'b1;
    rdata  = 32'h1c000008;
    #1;
    chk("t2_ar2_done", 32'(arvalid), 32'd0);
    tick();
    rvalid = 1'b0;
    #1;
    chk("t2_dok2", 32'(inst_sram_data_ok), 32'd1);
    chk("t2_rdata2", inst_sram_rdata, 32'h1c000008);
    tick();
    #1;
    chk("t2_cnt_end", 32'(rd_outstanding), 32'd0);

    // arready stalled for 5 cycles; AR held stable, no second accept
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c000100;
    arready        = 1'b0;
    #1;
    chk("t3_acc", 32'(inst_sram_addr_ok), 32'd1);
    tick();
    inst_sram_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c000200;
      end
      #1;
      chk("t3_arvalid", 32'(arvalid), 32'd1);
      chk("t3_araddr", araddr, 32'h1c000100);
      chk("t3_no_acc", 32'(inst_sram_addr_ok), 32'd0);
      tick();
    end
    inst_sram_req = 1'b0;
    arready       = 1'b1;
    #1;
    chk("t3_arvalid_last", 32'(arvalid), 32'd1);
    tick();
    #1;
    chk("t3_ar_done", 32'(arvalid), 32'd0);

    // error response flagged only in the data_ok cycle
    rvalid = 1'b1;
    rdata  = 32'hdeadbeef;
    rresp  = 2'b10;
    #1;
    chk("t4_err_pre", 32'(rresp_err), 32'd0);
    tick();
    rvalid = 1'b0;
    rresp  = 2'b00;
    #1;
    chk("t4_dok", 32'(inst_sram_data_ok), 32'd1);
    chk("t4_err", 32'(rresp_err), 32'd1);
    chk("t4_rdata", inst_sram_rdata, 32'hdeadbeef);
    tick();
    #1;
    chk("t4_err_drop", 32'(rresp_err), 32'd0);
    chk("t4_cnt", 32'(rd_outstanding), 32'd0);

    // stray R beat with nothing outstanding: pulse data_ok, count stays 0
    rvalid = 1'b1;
    rdata  = 32'h55aa55aa;
    tick();
    rvalid = 1'b0;
    #1;
    chk("t5_stray_dok", 32'(inst_sram_data_ok), 32'd1);
    chk("t5_stray_cnt", 32'(rd_outstanding), 32'd0);
    tick();
    #1;
    chk("t5_stray_cnt2", 32'(rd_outstanding), 32'd0);

    // write request: never accepted, sticky error
    inst_sram_req  = 1'b1;
    inst_sram_wr   = 1'b1;
    inst_sram_addr = 32'h1c000300;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_wr_no_acc", 32'(inst_sram_addr_ok), 32'd0);
      chk("t6_wr_no_ar", 32'(arvalid), 32'd0);
      tick();
    end
    inst_sram_req = 1'b0;
    inst_sram_wr  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_wr_err", 32'(wr_req_err), 32'd1);
      chk("t6_wr_no_ar2", 32'(arvalid), 32'd0);
      tick();
    end

    // asynchronous reset while AR pending
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c000400;
    arready        = 1'b0;
    #1;
    chk("t7_acc", 32'(inst_sram_addr_ok), 32'd1);
    tick();
    inst_sram_req = 1'b0;
    #1;
    chk("t7_arvalid", 32'(arvalid), 32'd1);
    chk("t7_cnt1", 32'(rd_outstanding), 32'd1);
    resetn = 1'b0;
    #1;
    chk("t7_arst_arvalid", 32'(arvalid), 32'd0);
    chk("t7_arst_cnt", 32'(rd_outstanding), 32'd0);
    chk("t7_arst_dok", 32'(inst_sram_data_ok), 32'd0);
    chk("t7_arst_wr_err", 32'(wr_req_err), 32'd0);
    chk("t7_arst_araddr", araddr, 32'd0);
    chk("t7_arst_rready", 32'(rready), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    #1;
    chk("t7_rready_up", 32'(rready), 32'd1);
    single_read("t7_resume", 32'h1c000500, 2'd1, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
